// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs data-memory accesses over a req/ack handshake,
// stalls the front of the pipeline while an access is pending, and loads MEM/WB.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_MEM,
    input  logic [31:0] ALU_MEM,
    input  logic [31:0] dato_B_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic [4:0]  rt_MEM,
    input  logic        Mux_flag_3_MEM,
    input  logic        mem_flag_rd_MEM,
    input  logic        mem_flag_wr_MEM,
    input  logic        banco_flag_wr_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        valid_WB,
    output logic [31:0] ALU_WB,
    output logic [31:0] dato_mem_WB,
    output logic [4:0]  rd_WB,
    output logic [4:0]  rt_WB,
    output logic        Mux_flag_3_WB,
    output logic        banco_flag_wr_WB,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic        is_mem, aligned, acc, is_load, misalign;
    logic        wb_load, wb_banco, set_mis, set_to;
    logic [31:0] wb_dato;

    // A set write flag takes priority, so rd+wr together is a store.
    assign is_mem   = valid_MEM & (mem_flag_rd_MEM | mem_flag_wr_MEM);
    assign aligned  = (ALU_MEM[1:0] == 2'b00);
    assign acc      = is_mem & aligned;
    assign misalign = is_mem & ~aligned;
    assign is_load  = mem_flag_rd_MEM & ~mem_flag_wr_MEM;

    // Memory port is quiet outside REQ; address/data come from the held EX/MEM slot.
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req & mem_flag_wr_MEM;
    assign dmem_addr  = dmem_req ? ALU_MEM : 32'h0;
    assign dmem_wdata = dmem_req ? dato_B_MEM : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_out = 1'b0;
        wb_load   = 1'b0;
        wb_banco  = banco_flag_wr_MEM;
        wb_dato   = 32'h0;
        set_mis   = 1'b0;
        set_to    = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    stall_out = 1'b1;
                    state_nxt = REQ;
                    cnt_nxt   = '0;
                end else begin
                    wb_load = 1'b1;
                    if (misalign) begin
                        wb_banco = 1'b0;
                        set_mis  = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_nxt = cnt + CW'(1);
                // Ack in the timeout cycle still completes the access.
                if (dmem_ack) begin
                    wb_load   = 1'b1;
                    wb_dato   = is_load ? dmem_rdata : 32'h0;
                    state_nxt = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    set_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MEM/WB register: either the EX/MEM slot or a bubble every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_WB         <= 1'b0;
            ALU_WB           <= 32'h0;
            dato_mem_WB      <= 32'h0;
            rd_WB            <= 5'h0;
            rt_WB            <= 5'h0;
            Mux_flag_3_WB    <= 1'b0;
            banco_flag_wr_WB <= 1'b0;
            misalign_err     <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            if (wb_load) begin
                valid_WB         <= valid_MEM;
                ALU_WB           <= ALU_MEM;
                dato_mem_WB      <= wb_dato;
                rd_WB            <= rd_MEM;
                rt_WB            <= rt_MEM;
                Mux_flag_3_WB    <= Mux_flag_3_MEM;
                banco_flag_wr_WB <= wb_banco;
            end else begin
                valid_WB         <= 1'b0;
                ALU_WB           <= 32'h0;
                dato_mem_WB      <= 32'h0;
                rd_WB            <= 5'h0;
                rt_WB            <= 5'h0;
                Mux_flag_3_WB    <= 1'b0;
                banco_flag_wr_WB <= 1'b0;
            end
            if (set_mis) misalign_err <= 1'b1;
            if (set_to)  timeout_err  <= 1'b1;
        end
    end

endmodule
